// File: rtl/kat_adc_autoconfig.sv
// Power-up sequencer that replays a fixed 5-entry KAT ADC register table into the SPI config FSM.
// Optional per-write done timeout is compiled in with `define KATADC_AUTOCFG_TIMEOUT_EN.
module kat_adc_autoconfig #(
   parameter bit          INTERLEAVED    = 1'b0,
   parameter bit          AUTO_START     = 1'b1,
   parameter int unsigned WAIT_CYCLES    = 256,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        wbs_clk_i,
   input  logic        wbs_rst_n_i,
   input  logic        start_i,
   input  logic        config_done_i,
   output logic [3:0]  config_addr_o,
   output logic [15:0] config_data_o,
   output logic        config_start_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [2:0]  index_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_ISSUE, S_ACK_WAIT, S_BUSY_WAIT, S_NEXT, S_DONE, S_ERROR
   } state_t;

   localparam logic [15:0] LP_WAIT_LOAD = 16'(WAIT_CYCLES - 1);
   localparam logic [2:0]  LP_LAST_IDX  = 3'd4;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_first;
   logic [15:0] r_cnt;
   logic [2:0]  r_index;
   logic [3:0]  r_addr;
   logic [15:0] r_data;
   logic        w_trigger;
   logic        w_last;
   logic        w_tmo;
   logic        w_enter_settle;
   logic        w_enter_issue;
   logic [2:0]  w_entry_idx;

   function automatic logic [3:0] f_tbl_addr(input logic [2:0] idx);
      case (idx)
         3'd0:    f_tbl_addr = 4'h0;
         3'd1:    f_tbl_addr = 4'h1;
         3'd2:    f_tbl_addr = 4'h2;
         3'd3:    f_tbl_addr = 4'h3;
         default: f_tbl_addr = 4'h9;
      endcase
   endfunction

   function automatic logic [15:0] f_tbl_data(input logic [2:0] idx);
      case (idx)
         3'd0:    f_tbl_data = INTERLEAVED ? 16'h7C2C : 16'h7CBC;
         3'd4:    f_tbl_data = 16'h0001;
         default: f_tbl_data = 16'h0000;
      endcase
   endfunction

   // r_first is high only in the first cycle after reset release (auto-start window).
   assign w_trigger      = (r_first & AUTO_START) | start_i;
   assign w_last         = (r_index == LP_LAST_IDX);
   assign w_enter_settle = (w_state_nxt == S_SETTLE) && (r_state != S_SETTLE);
   assign w_enter_issue  = (w_state_nxt == S_ISSUE) && (r_state != S_ISSUE);
   assign w_entry_idx    = (r_state == S_NEXT) ? (r_index + 3'd1) : r_index;

`ifdef KATADC_AUTOCFG_TIMEOUT_EN
   localparam logic [15:0] LP_TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_tmr;

   assign w_tmo = (r_tmr == 16'd0);

   always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
      if (!wbs_rst_n_i) begin
         r_tmr <= 16'd0;
      end else if (r_state == S_ISSUE && w_state_nxt == S_ACK_WAIT) begin
         r_tmr <= LP_TMO_LOAD;
      end else if ((r_state == S_ACK_WAIT || r_state == S_BUSY_WAIT) && r_tmr != 16'd0) begin
         r_tmr <= r_tmr - 16'd1;
      end
   end
`else
   logic w_unused_tmo;
   assign w_unused_tmo = |16'(TIMEOUT_CYCLES);
   assign w_tmo        = 1'b0;
`endif

   always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
      if (!wbs_rst_n_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:      if (w_trigger) w_state_nxt = S_SETTLE;
         S_SETTLE:    if (r_cnt == 16'd0 && config_done_i) w_state_nxt = S_ISSUE;
         S_ISSUE:     if (config_done_i) w_state_nxt = S_ACK_WAIT;
         S_ACK_WAIT: begin
            if (!config_done_i) w_state_nxt = S_BUSY_WAIT;
            else if (w_tmo)     w_state_nxt = S_ERROR;
         end
         S_BUSY_WAIT: begin
            if (config_done_i) w_state_nxt = S_NEXT;
            else if (w_tmo)    w_state_nxt = S_ERROR;
         end
         S_NEXT:      w_state_nxt = w_last ? S_DONE : S_ISSUE;
         S_DONE:      if (start_i) w_state_nxt = S_SETTLE;
         S_ERROR:     if (start_i) w_state_nxt = S_SETTLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // The start pulse is gated by config_done_i so a write is never launched into a busy controller.
   always_comb begin
      config_start_o = 1'b0;
      busy_o         = 1'b0;
      done_o         = 1'b0;
      error_o        = 1'b0;
      case (r_state)
         S_SETTLE, S_ACK_WAIT, S_BUSY_WAIT, S_NEXT: busy_o = 1'b1;
         S_ISSUE: begin
            busy_o         = 1'b1;
            config_start_o = config_done_i;
         end
         S_DONE:  done_o = 1'b1;
`ifdef KATADC_AUTOCFG_TIMEOUT_EN
         S_ERROR: error_o = 1'b1;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
      if (!wbs_rst_n_i) begin
         r_first <= 1'b1;
         r_cnt   <= 16'd0;
         r_index <= 3'd0;
         r_addr  <= 4'h0;
         r_data  <= 16'h0000;
      end else begin
         r_first <= 1'b0;
         if (w_enter_settle) begin
            r_cnt   <= LP_WAIT_LOAD;
            r_index <= 3'd0;
         end else begin
            if (r_state == S_SETTLE && r_cnt != 16'd0) begin
               r_cnt <= r_cnt - 16'd1;
            end
            if (r_state == S_NEXT && !w_last) begin
               r_index <= r_index + 3'd1;
            end
         end
         // Address/data stay latched from ISSUE until the next entry is issued.
         if (w_enter_issue) begin
            r_addr <= f_tbl_addr(w_entry_idx);
            r_data <= f_tbl_data(w_entry_idx);
         end
      end
   end

   assign config_addr_o = r_addr;
   assign config_data_o = r_data;
   assign index_o       = r_index;

endmodule

// File: tb/tb_kat_adc_autoconfig.sv
// Bench for kat_adc_autoconfig: two instances (auto-start/normal, manual-start/interleaved)
// each driven by a simple SPI-controller done model; writes checked against an expected queue.
module tb_kat_adc_autoconfig;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n  [2];
   logic        start  [2];
   logic        done   [2];
   logic [3:0]  addr   [2];
   logic [15:0] data   [2];
   logic        cstart [2];
   logic        busy   [2];
   logic        dn     [2];
   logic        err    [2];
   logic [2:0]  idx    [2];

   logic        m_done [2] = '{1'b1, 1'b1};
   int          m_cnt  [2];
   int          m_len  [2];
   bit          m_hang [2];
   bit          m_hold [2];

   logic [19:0] exp_q0 [$];
   logic [19:0] exp_q1 [$];
   int          total = 0;
   int          bad   = 0;
   int          n_starts [2];
   logic [19:0] mon_got;
   logic [19:0] mon_exp;
   bit          mon_have;

   kat_adc_autoconfig #(
      .INTERLEAVED(1'b0), .AUTO_START(1'b1), .WAIT_CYCLES(4), .TIMEOUT_CYCLES(16)
   ) u_dut_a (
      .wbs_clk_i(clk), .wbs_rst_n_i(rst_n[0]), .start_i(start[0]), .config_done_i(done[0]),
      .config_addr_o(addr[0]), .config_data_o(data[0]), .config_start_o(cstart[0]),
      .busy_o(busy[0]), .done_o(dn[0]), .error_o(err[0]), .index_o(idx[0])
   );

   kat_adc_autoconfig #(
      .INTERLEAVED(1'b1), .AUTO_START(1'b0), .WAIT_CYCLES(4), .TIMEOUT_CYCLES(16)
   ) u_dut_b (
      .wbs_clk_i(clk), .wbs_rst_n_i(rst_n[1]), .start_i(start[1]), .config_done_i(done[1]),
      .config_addr_o(addr[1]), .config_data_o(data[1]), .config_start_o(cstart[1]),
      .busy_o(busy[1]), .done_o(dn[1]), .error_o(err[1]), .index_o(idx[1])
   );

   // Controller model: done drops the cycle after a start, returns m_len cycles later.
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (cstart[g]) begin
            m_done[g] <= 1'b0;
            m_cnt[g]  <= m_len[g];
         end else if (!m_done[g] && !m_hang[g]) begin
            if (m_cnt[g] <= 1) m_done[g] <= 1'b1;
            else               m_cnt[g]  <= m_cnt[g] - 1;
         end
      end
   end

   always_comb begin
      for (int g = 0; g < 2; g++) done[g] = m_done[g] & ~m_hold[g];
   end

   // Scoreboard: every start pulse pops the next expected {addr,data}.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (cstart[g] === 1'b1) begin
            n_starts[g]++;
            total++;
            if (done[g] !== 1'b1) begin
               bad++;
               $display("FAIL start_with_done_low dut%0d: config_done_i=%b required 1", g, done[g]);
            end
            mon_got  = {addr[g], data[g]};
            mon_have = 1'b0;
            if (g == 0 && exp_q0.size() > 0) begin
               mon_exp = exp_q0.pop_front(); mon_have = 1'b1;
            end else if (g == 1 && exp_q1.size() > 0) begin
               mon_exp = exp_q1.pop_front(); mon_have = 1'b1;
            end
            total++;
            if (!mon_have) begin
               bad++;
               $display("FAIL unexpected_start dut%0d: got addr=%h data=%h required no start", g, addr[g], data[g]);
            end else if (mon_got !== mon_exp) begin
               bad++;
               $display("FAIL write dut%0d: got addr=%h data=%h required addr=%h data=%h",
                        g, mon_got[19:16], mon_got[15:0], mon_exp[19:16], mon_exp[15:0]);
            end
         end
      end
   end

   task automatic push_table(input int g, input bit il, input int n);
      logic [19:0] t [5];
      t[0] = {4'h0, il ? 16'h7C2C : 16'h7CBC};
      t[1] = {4'h1, 16'h0000};
      t[2] = {4'h2, 16'h0000};
      t[3] = {4'h3, 16'h0000};
      t[4] = {4'h9, 16'h0001};
      for (int i = 0; i < n; i++) begin
         if (g == 0) exp_q0.push_back(t[i]);
         else        exp_q1.push_back(t[i]);
      end
   endtask

   task automatic pulse_start(input int g);
      @(negedge clk); start[g] = 1'b1;
      @(negedge clk); start[g] = 1'b0;
   endtask

   task automatic wait_start(input int g, input logic [2:0] want, input int budget,
                             input string name, output int cyc);
      bit seen = 1'b0;
      cyc = 0;
      while (!seen && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (cstart[g] === 1'b1 && idx[g] === want) seen = 1'b1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s: got no start for index %0d in %0d cycles required one", name, want, budget);
      end
   endtask

   task automatic wait_done(input int g, input int budget, input string name);
      int cyc = 0;
      while (dn[g] !== 1'b1 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      total++;
      if (dn[g] !== 1'b1) begin
         bad++;
         $display("FAIL %s: done_o=%b after %0d cycles required 1", name, dn[g], budget);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         total++;
         if ({addr[g], data[g], cstart[g], busy[g], dn[g], err[g], idx[g]} !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs dut%0d: got addr=%h data=%h start=%b busy=%b done=%b err=%b idx=%0d required all 0",
                     g, addr[g], data[g], cstart[g], busy[g], dn[g], err[g], idx[g]);
         end
      end
   endtask

   task automatic test_auto_sequence();
      int cyc;
      m_len[0] = 600;
      push_table(0, 1'b0, 5);
      @(negedge clk); rst_n[0] = 1'b1;
      wait_start(0, 3'd0, 20, "auto_first_start", cyc);
      total++;
      if (cyc !== 5) begin
         bad++; $display("FAIL auto_latency: got %0d cycles required 5", cyc);
      end
      total++;
      if (busy[0] !== 1'b1) begin
         bad++; $display("FAIL auto_busy: got %b required 1", busy[0]);
      end
      wait_done(0, 4000, "auto_done");
      total++;
      if ({busy[0], err[0], idx[0]} !== {1'b0, 1'b0, 3'd4}) begin
         bad++; $display("FAIL auto_final: got busy=%b err=%b idx=%0d required 0 0 4", busy[0], err[0], idx[0]);
      end
      total++;
      if (exp_q0.size() != 0 || n_starts[0] != 5) begin
         bad++; $display("FAIL auto_count: got starts=%0d left=%0d required 5 0", n_starts[0], exp_q0.size());
      end
   endtask

   task automatic test_manual_interleaved();
      int cyc;
      m_len[1] = 30;
      @(negedge clk); rst_n[1] = 1'b1;
      repeat (20) @(negedge clk);
      total++;
      if (busy[1] !== 1'b0 || n_starts[1] != 0) begin
         bad++; $display("FAIL manual_idle: got busy=%b starts=%0d required 0 0", busy[1], n_starts[1]);
      end
      push_table(1, 1'b1, 5);
      pulse_start(1);
      wait_start(1, 3'd1, 200, "manual_entry1", cyc);
      pulse_start(1);
      wait_done(1, 500, "manual_done");
      total++;
      if (exp_q1.size() != 0 || n_starts[1] != 5 || idx[1] !== 3'd4) begin
         bad++; $display("FAIL manual_final: got starts=%0d left=%0d idx=%0d required 5 0 4", n_starts[1], exp_q1.size(), idx[1]);
      end
   endtask

   task automatic test_done_held_low();
      int cyc;
      int base = n_starts[0];
      m_len[0]  = 20;
      m_hold[0] = 1'b1;
      push_table(0, 1'b0, 5);
      pulse_start(0);
      total++;
      if (dn[0] !== 1'b0 || busy[0] !== 1'b1) begin
         bad++; $display("FAIL rerun_flags: got done=%b busy=%b required 0 1", dn[0], busy[0]);
      end
      repeat (10) @(negedge clk);
      total++;
      if (n_starts[0] != base || cstart[0] !== 1'b0 || busy[0] !== 1'b1) begin
         bad++; $display("FAIL held_low_no_start: got starts=%0d busy=%b required %0d 1", n_starts[0], busy[0], base);
      end
      m_hold[0] = 1'b0;
      wait_start(0, 3'd0, 5, "held_low_release", cyc);
      total++;
      if (cyc !== 1) begin
         bad++; $display("FAIL held_low_latency: got %0d cycles required 1", cyc);
      end
      wait_done(0, 500, "held_low_done");
      total++;
      if (exp_q0.size() != 0 || n_starts[0] != base + 5) begin
         bad++; $display("FAIL held_low_count: got starts=%0d required %0d", n_starts[0], base + 5);
      end
   endtask

   task automatic test_timeout();
      int cyc;
      m_len[1] = 8;
      push_table(1, 1'b1, 5);
      pulse_start(1);
      wait_start(1, 3'd2, 200, "tmo_entry2", cyc);
      m_hang[1] = 1'b1;
`ifdef KATADC_AUTOCFG_TIMEOUT_EN
      cyc = 0;
      while (err[1] !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      total++;
      if (cyc !== 17) begin
         bad++; $display("FAIL tmo_latency: got error after %0d cycles required 17", cyc);
      end
      total++;
      if ({err[1], busy[1], dn[1], idx[1]} !== {1'b1, 1'b0, 1'b0, 3'd2}) begin
         bad++; $display("FAIL tmo_flags: got err=%b busy=%b done=%b idx=%0d required 1 0 0 2", err[1], busy[1], dn[1], idx[1]);
      end
      m_hang[1] = 1'b0;
      repeat (12) @(negedge clk);
      exp_q1.delete();
      push_table(1, 1'b1, 5);
      pulse_start(1);
      total++;
      if (err[1] !== 1'b0 || busy[1] !== 1'b1) begin
         bad++; $display("FAIL tmo_restart: got err=%b busy=%b required 0 1", err[1], busy[1]);
      end
      wait_done(1, 500, "tmo_replay_done");
`else
      repeat (100) @(negedge clk);
      total++;
      if ({err[1], busy[1], dn[1], idx[1]} !== {1'b0, 1'b1, 1'b0, 3'd2}) begin
         bad++; $display("FAIL no_tmo_wait: got err=%b busy=%b done=%b idx=%0d required 0 1 0 2", err[1], busy[1], dn[1], idx[1]);
      end
      m_hang[1] = 1'b0;
      wait_done(1, 300, "no_tmo_done");
`endif
      total++;
      if (exp_q1.size() != 0 || idx[1] !== 3'd4 || err[1] !== 1'b0) begin
         bad++; $display("FAIL tmo_final: got left=%0d idx=%0d err=%b required 0 4 0", exp_q1.size(), idx[1], err[1]);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      int base = n_starts[0];
      m_len[0] = 40;
      push_table(0, 1'b0, 5);
      pulse_start(0);
      wait_start(0, 3'd3, 400, "mid_entry3", cyc);
      repeat (5) @(negedge clk);
      total++;
      if (busy[0] !== 1'b1 || idx[0] !== 3'd3) begin
         bad++; $display("FAIL mid_pre_reset: got busy=%b idx=%0d required 1 3", busy[0], idx[0]);
      end
      #2 rst_n[0] = 1'b0;
      #1;
      total++;
      if ({addr[0], data[0], cstart[0], busy[0], dn[0], err[0], idx[0]} !== 27'd0) begin
         bad++; $display("FAIL mid_async_reset: got addr=%h data=%h busy=%b idx=%0d required all 0",
                         addr[0], data[0], busy[0], idx[0]);
      end
      exp_q0.delete();
      push_table(0, 1'b0, 5);
      @(negedge clk);
      @(negedge clk); rst_n[0] = 1'b1;
      wait_start(0, 3'd0, 200, "mid_restart", cyc);
      wait_done(0, 600, "mid_done");
      total++;
      if (exp_q0.size() != 0 || n_starts[0] != base + 9 || idx[0] !== 3'd4) begin
         bad++; $display("FAIL mid_final: got starts=%0d left=%0d idx=%0d required %0d 0 4",
                         n_starts[0], exp_q0.size(), idx[0], base + 9);
      end
   endtask

   initial begin
      rst_n    = '{1'b0, 1'b0};
      start    = '{1'b0, 1'b0};
      m_len    = '{600, 30};
      m_hang   = '{1'b0, 1'b0};
      m_hold   = '{1'b0, 1'b0};
      n_starts = '{0, 0};
      test_reset();
      test_auto_sequence();
      test_manual_interleaved();
      test_done_held_low();
      test_timeout();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
